// File: rtl/display_pkg.sv
// Board packing shared by the VGA tile renderer and everything that feeds it.
// A board is 16 tiles of 4-bit exponent, tile 0 in the least-significant nibble.
package display_pkg;
    localparam int BOARD_W   = 64;
    localparam int TILE_W    = 4;
    localparam int NUM_TILES = BOARD_W / TILE_W;

    typedef logic [BOARD_W-1:0] board_t;
    typedef logic [TILE_W-1:0]  tile_t;

    typedef enum logic {PH_SHOW = 1'b0, PH_BLANK = 1'b1} blink_phase_t;

    function automatic tile_t tile_at(board_t b, int idx);
        return b[idx*TILE_W +: TILE_W];
    endfunction
endpackage

// File: rtl/board_frame_scheduler_if.sv
// Board update handshake between the game logic (master) and the frame scheduler (slave).
interface board_frame_scheduler_if;
    import display_pkg::*;

    logic   upd_valid;
    board_t upd_board;
    logic   upd_ready;

    modport master (output upd_valid, output upd_board, input upd_ready);
    modport slave  (input upd_valid, input upd_board, output upd_ready);
endinterface

// File: rtl/board_fifo2.sv
// Two-entry board FIFO, head in slot 0. Push is ignored when full; pop on empty is ignored.
module board_fifo2
    import display_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  board_t     i_din,
    input  logic       i_pop,
    output board_t     o_head,
    output logic [1:0] o_count
);
    board_t     r_mem [2];
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop && (r_count != 2'd0);
    assign o_head  = r_mem[0];
    assign o_count = r_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_count  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    r_mem[r_count[0]] <= i_din;
                    r_count           <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem[0] <= r_mem[1];
                    r_count  <= r_count - 2'd1;
                end
                // Only reachable with one entry: the new board replaces the departing head.
                2'b11:   r_mem[0] <= i_din;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/board_frame_scheduler.sv
// Buffers board updates and commits them to the display only at frame starts,
// holding each board for MIN_FRAMES frames, with frame-synchronous blinking.
module board_frame_scheduler
    import display_pkg::*;
#(
    parameter int MIN_FRAMES       = 4,
    parameter int BLINK_FRAMES     = 16,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,     // active-low, asynchronous
    input  logic                     i_vsync,
    board_frame_scheduler_if.slave   upd,
    input  logic                     i_blink_en,
    output board_t                   o_disp_board,
    output logic                     o_disp_blank,
    output logic                     o_frame_tick,
    output logic [1:0]               o_pending,
    output logic [7:0]               o_stall_cnt
);
    localparam logic       VS_ACT    = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [3:0] HOLD_INIT = 4'(MIN_FRAMES - 1);
    localparam logic [7:0] BLINK_TOP = 8'(BLINK_FRAMES - 1);

    logic         r_vsync_prev;
    logic         r_frame_tick;
    logic [3:0]   r_hold;
    logic [7:0]   r_blink_cnt;
    blink_phase_t r_phase;
    board_t       r_disp_board;
    logic [7:0]   r_stall_cnt;

    board_t       w_head;
    logic [1:0]   w_count;
    logic         w_ready;
    logic         w_push;
    logic         w_pop;
    logic         w_vs_start;

    assign w_ready       = (w_count != 2'd2);
    assign upd.upd_ready = w_ready;
    assign w_push        = upd.upd_valid && w_ready;
    assign w_pop         = r_frame_tick && (r_hold == 4'd0) && (w_count != 2'd0);
    // Previous vsync resets to the active level so the first tick needs a real edge.
    assign w_vs_start    = (i_vsync == VS_ACT) && (r_vsync_prev != VS_ACT);

    board_fifo2 u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (upd.upd_board),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_vsync_prev <= VS_ACT;
            r_frame_tick <= 1'b0;
            r_hold       <= 4'd0;
            r_blink_cnt  <= 8'd0;
            r_phase      <= PH_SHOW;
            r_disp_board <= '0;
            r_stall_cnt  <= 8'd0;
        end else begin
            r_vsync_prev <= i_vsync;
            r_frame_tick <= w_vs_start;
            if (upd.upd_valid && !w_ready && (r_stall_cnt != 8'hFF))
                r_stall_cnt <= r_stall_cnt + 8'd1;
            if (r_frame_tick) begin
                if (w_pop) begin
                    r_disp_board <= w_head;
                    r_hold       <= HOLD_INIT;
                end else if (r_hold != 4'd0) begin
                    r_hold <= r_hold - 4'd1;
                end
                if (i_blink_en) begin
                    if (r_blink_cnt == BLINK_TOP) begin
                        r_blink_cnt <= 8'd0;
                        r_phase     <= (r_phase == PH_SHOW) ? PH_BLANK : PH_SHOW;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 8'd1;
                    end
                end else begin
                    r_blink_cnt <= 8'd0;
                    r_phase     <= PH_SHOW;
                end
            end
        end
    end

    assign o_disp_board = r_disp_board;
    assign o_disp_blank = (r_phase == PH_BLANK);
    assign o_frame_tick = r_frame_tick;
    assign o_pending    = w_count;
    assign o_stall_cnt  = r_stall_cnt;
endmodule

// File: tb/tb_board_frame_scheduler.sv
// Bench for board_frame_scheduler: reset/table vectors, directed pacing, stall,
// blink and reset sequences, then random traffic against a queue-based model.
module tb_board_frame_scheduler;
    import display_pkg::*;

    localparam int   MIN_FRAMES       = 4;
    localparam int   BLINK_FRAMES     = 2;
    localparam bit   VSYNC_ACTIVE_LOW = 1'b1;
    localparam logic VS_ACT           = VSYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    if (MIN_FRAMES < 1 || MIN_FRAMES > 15) begin : g_bad_min
        initial $fatal(1, "MIN_FRAMES outside 1..15");
    end
    if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink
        initial $fatal(1, "BLINK_FRAMES outside 1..255");
    end

    localparam board_t BRD0  = 64'h0000_0000_0000_1001;
    localparam board_t BRD_A = 64'h1234_0000_0000_0001;
    localparam board_t BRD_B = 64'h0000_5678_0000_0002;
    localparam board_t BRD_C = 64'h0000_0000_9ABC_0003;
    localparam board_t BRD_D = 64'hDDDD_0000_0000_0004;
    localparam board_t BRD_E = 64'hEEEE_0000_0000_0005;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = VS_ACT;
    logic       blink_en = 1'b0;
    board_t     disp_board;
    logic       disp_blank, frame_tick;
    logic [1:0] pending;
    logic [7:0] stall_cnt;

    board_frame_scheduler_if upd_if();

    board_frame_scheduler #(
        .MIN_FRAMES(MIN_FRAMES), .BLINK_FRAMES(BLINK_FRAMES), .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_vsync(vsync), .upd(upd_if), .i_blink_en(blink_en),
        .o_disp_board(disp_board), .o_disp_blank(disp_blank), .o_frame_tick(frame_tick),
        .o_pending(pending), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: a queue of boards, ticks since last commit, and enabled ticks since blink began.
    board_t m_q[$];
    board_t m_disp;
    bit     m_tick, m_prev_act;
    int     m_since, m_bn, m_stall;

    task automatic model_reset();
        m_q.delete();
        m_disp = '0; m_tick = 0; m_prev_act = 1;
        m_since = MIN_FRAMES; m_bn = 0; m_stall = 0;
    endtask

    function automatic logic m_blank();
        return ((m_bn / BLINK_FRAMES) % 2) == 1;
    endfunction

    task automatic model_clock();
        bit act, full;
        if (!rst) begin model_reset(); return; end
        act  = (vsync == VS_ACT);
        full = (m_q.size() >= 2);
        if (upd_if.upd_valid && full && m_stall < 255) m_stall++;
        if (m_tick) begin
            if (m_since < MIN_FRAMES) m_since++;
            if (m_since >= MIN_FRAMES && m_q.size() > 0) begin
                m_disp  = m_q.pop_front();
                m_since = 0;
            end
            if (blink_en) m_bn++; else m_bn = 0;
        end
        if (upd_if.upd_valid && !full) m_q.push_back(upd_if.upd_board);
        m_tick     = act && !m_prev_act;
        m_prev_act = act;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("tick",    64'(frame_tick),       64'(m_tick));
        chk("disp",    disp_board,            m_disp);
        chk("blank",   64'(disp_blank),       64'(m_blank()));
        chk("pending", 64'(pending),          64'(m_q.size()));
        chk("ready",   64'(upd_if.upd_ready), 64'(m_q.size() < 2));
        chk("stall",   64'(stall_cnt),        64'(m_stall));
    endtask

    task automatic step();
        check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive(input bit act, input bit valid, input board_t b);
        vsync = act ? VS_ACT : ~VS_ACT;
        upd_if.upd_valid = valid;
        upd_if.upd_board = b;
    endtask

    task automatic run_frame();
        drive(0, 0, '0); repeat (3) step();
        drive(1, 0, '0); repeat (2) step();
    endtask

    typedef struct {
        bit     act;
        bit     valid;
        board_t board;
        bit     e_tick;
        int     e_pend;
        board_t e_disp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 64'h0, 1'b0, 0, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 64'h0, 1'b0, 0, 64'h0};
        tbl[2] = '{1'b0, 1'b1, BRD0,  1'b0, 1, 64'h0};
        tbl[3] = '{1'b0, 1'b0, 64'h0, 1'b0, 1, 64'h0};
        tbl[4] = '{1'b1, 1'b0, 64'h0, 1'b1, 1, 64'h0};
        tbl[5] = '{1'b1, 1'b0, 64'h0, 1'b0, 0, BRD0};
        tbl[6] = '{1'b1, 1'b0, 64'h0, 1'b0, 0, BRD0};
        tbl[7] = '{1'b0, 1'b0, 64'h0, 1'b0, 0, BRD0};

        model_reset();
        drive(1, 0, '0);
        @(negedge clk);
        chk("rst_disp", disp_board, 64'h0);
        chk("rst_ready", 64'(upd_if.upd_ready), 64'h1);
        chk("rst_pending", 64'(pending), 64'h0);
        step();
        rst = 1'b1;

        // Vsync held active out of reset: no tick until a genuine edge.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].act, tbl[i].valid, tbl[i].board);
            step();
            chk($sformatf("tbl%0d_tick", i), 64'(frame_tick), 64'(tbl[i].e_tick));
            chk($sformatf("tbl%0d_pend", i), 64'(pending), 64'(tbl[i].e_pend));
            chk($sformatf("tbl%0d_disp", i), disp_board, tbl[i].e_disp);
            chk($sformatf("tbl%0d_ready", i), 64'(upd_if.upd_ready), 64'(tbl[i].e_pend < 2));
        end

        // Let the hold from the first commit expire, then A/B pacing plus a stalled C.
        repeat (3) run_frame();
        drive(0, 1, BRD_A); step();
        drive(0, 1, BRD_B); step();
        chk("ab_pending", 64'(pending), 64'd2);
        drive(0, 1, BRD_C);
        for (int i = 0; i < 10; i++) begin
            chk("stall_ready", 64'(upd_if.upd_ready), 64'h0);
            step();
        end
        chk("stall_cnt10", 64'(stall_cnt), 64'd10);
        drive(1, 1, BRD_C); step(); step();
        chk("a_commit", disp_board, BRD_A);
        chk("a_pop_pending", 64'(pending), 64'd1);
        chk("c_ready", 64'(upd_if.upd_ready), 64'h1);
        step();
        chk("c_accept", 64'(pending), 64'd2);
        for (int f = 2; f <= 5; f++) begin
            run_frame();
            chk($sformatf("b_tick%0d", f), disp_board, (f < 5) ? BRD_A : BRD_B);
        end
        chk("b_pending", 64'(pending), 64'd1);

        // Blink: phase after n enabled ticks is (n / BLINK_FRAMES) odd.
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            run_frame();
            chk($sformatf("blink%0d", f), 64'(disp_blank), 64'(((f + 1) / BLINK_FRAMES) % 2));
        end
        chk("c_commit_while_blink", disp_board, BRD_C);
        blink_en = 1'b0;
        drive(0, 0, '0); step(); step();
        chk("blank_hold", 64'(disp_blank), 64'h1);
        run_frame();
        chk("blank_clear", 64'(disp_blank), 64'h0);

        // Mid-operation reset with two buffered boards and the display blanked.
        blink_en = 1'b1;
        repeat (2) run_frame();
        drive(0, 1, BRD_D); step();
        drive(0, 1, BRD_E); step();
        drive(0, 0, '0);
        chk("pre_rst_pending", 64'(pending), 64'd2);
        chk("pre_rst_blank", 64'(disp_blank), 64'h1);
        rst = 1'b0; #1;
        chk("arst_disp", disp_board, 64'h0);
        chk("arst_blank", 64'(disp_blank), 64'h0);
        chk("arst_tick", 64'(frame_tick), 64'h0);
        chk("arst_pending", 64'(pending), 64'h0);
        chk("arst_stall", 64'(stall_cnt), 64'h0);
        chk("arst_ready", 64'(upd_if.upd_ready), 64'h1);
        model_reset();
        step();
        rst = 1'b1;
        blink_en = 1'b0;
        repeat (2) run_frame();
        chk("no_stale_disp", disp_board, 64'h0);
        chk("no_stale_pending", 64'(pending), 64'h0);

        // Random traffic against the model, with two asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            if (c == 1500 || c == 3000) begin
                rst = 1'b0; #1;
                model_reset();
                check_all();
                step();
                rst = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) blink_en = ~blink_en;
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, {$urandom, $urandom});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
